board_renderer: RTL

Sequencer that sits directly upstream of the pixel-copy engine. On a `start` pulse it optionally has the copy engine paint the full-screen game background. It then walks a tile map row by row and issues one 16×16 tile copy per non-empty cell, using a go/finished handshake. It reports `busy` while working and pulses `done` when the frame is complete.

---
 rtl/render_pkg.sv | 33 +++
 rtl/board_renderer_tile_counter.sv | 50 +++++
 rtl/board_renderer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/render_pkg.sv
// Shared constants and types for the board renderer and the copy engine side.
package render_pkg;

  // Copy-engine source memory selects
  localparam logic [1:0] MEM_TITLE = 2'b00;
  localparam logic [1:0] MEM_GAME  = 2'b01;
  localparam logic [1:0] MEM_END   = 2'b10;
  localparam logic [1:0] MEM_TILE  = 2'b11;

  // Tile geometry: tiles are square, TILE_PX a power of two
  localparam int TILE_PX    = 16;
  localparam int TILE_SHIFT = $clog2(TILE_PX);

  // Tile code meaning "nothing to draw"
  localparam logic [3:0] TILE_EMPTY = 4'd0;

  // Screen size in pixels
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  // Renderer sequencer states, exported for debug visibility
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BG_GO = 3'd1,
    S_ADDR  = 3'd2,
    S_READ  = 3'd3,
    S_ISSUE = 3'd4,
    S_WAIT  = 3'd5,
    S_NEXT  = 3'd6,
    S_DONE  = 3'd7
  } state_e;

endpackage

// File: rtl/board_renderer_tile_counter.sv
// Row/column scan counter over a GRID_W x GRID_H tile map, row-major order.
module tile_counter #(
  parameter int GRID_W = 20,
  parameter int GRID_H = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  output logic [8:0] col,
  output logic [7:0] row,
  output logic       last
);

  logic [8:0] col_q, col_d;
  logic [7:0] row_q, row_d;

  // Next count: clear wins over enable; column wraps into the next row
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (en) begin
      if (col_q == 9'(GRID_W - 1)) begin
        col_d = '0;
        row_d = (row_q == 8'(GRID_H - 1)) ? 8'd0 : row_q + 8'd1;
      end else begin
        col_d = col_q + 9'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == 9'(GRID_W - 1)) && (row_q == 8'(GRID_H - 1));

endmodule

// File: rtl/board_renderer.sv
// Frame sequencer: optional background copy, then one tile copy per
// non-empty map cell, handshaking with the copy engine via go/finished.
//
// Handshake: cp_go is a one-cycle request; cp_x/cp_y/cp_memory_select/
// cp_tile_select are valid in the cp_go cycle and held until the engine
// raises cp_finished, which is only honoured while a copy is outstanding.
module board_renderer
  import render_pkg::*;
#(
  parameter int GRID_W   = 20,
  parameter int GRID_H   = 15,
  parameter int ORIGIN_X = 0,
  parameter int ORIGIN_Y = 0,
  parameter bit DRAW_BG  = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [8:0] map_addr,
  input  logic [3:0] map_data,
  output logic       cp_go,
  output logic [8:0] cp_x,
  output logic [7:0] cp_y,
  output logic [1:0] cp_memory_select,
  output logic [3:0] cp_tile_select,
  input  logic       cp_finished,
  output logic       busy,
  output logic       done,
  output state_e     dbg_state
);

  state_e     state_q, state_d;
  logic       bg_phase_q, bg_phase_d;
  logic       cp_go_q, cp_go_d;
  logic [8:0] cp_x_q, cp_x_d;
  logic [7:0] cp_y_q, cp_y_d;
  logic [1:0] mem_q, mem_d;
  logic [3:0] tile_q, tile_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       cnt_clr, cnt_en, cnt_last;
  logic [8:0] col_cnt;
  logic [7:0] row_cnt;

  tile_counter #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H)
  ) u_tile_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .col    (col_cnt),
    .row    (row_cnt),
    .last   (cnt_last)
  );

  // Map address follows the counter flops directly, so it is valid in ADDR
  assign map_addr = ({1'b0, row_cnt} * 9'(GRID_W)) + col_cnt;

  // Next-state and registered-output logic. The background copy also
  // passes through NEXT; bg_phase marks that pass so cell (0,0) is not
  // skipped by a counter advance.
  always_comb begin
    state_d    = state_q;
    bg_phase_d = bg_phase_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    cp_x_d     = cp_x_q;
    cp_y_d     = cp_y_q;
    mem_d      = mem_q;
    tile_d     = tile_q;
    case (state_q)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (start) begin
          if (DRAW_BG) begin
            state_d    = S_BG_GO;
            bg_phase_d = 1'b1;
            mem_d      = MEM_GAME;
            cp_x_d     = '0;
            cp_y_d     = '0;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_BG_GO: state_d = S_WAIT;
      S_ADDR:  state_d = S_READ;
      S_READ: begin
        if (map_data == TILE_EMPTY) begin
          state_d = S_NEXT;
        end else begin
          state_d = S_ISSUE;
          tile_d  = map_data;
          mem_d   = MEM_TILE;
          cp_x_d  = 9'(ORIGIN_X) + (col_cnt << TILE_SHIFT);
          cp_y_d  = 8'(ORIGIN_Y) + (row_cnt << TILE_SHIFT);
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (cp_finished) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (bg_phase_q) begin
          bg_phase_d = 1'b0;
          state_d    = S_ADDR;
        end else if (cnt_last) begin
          state_d = S_DONE;
        end else begin
          cnt_en  = 1'b1;
          state_d = S_ADDR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    cp_go_d = (state_d == S_BG_GO) || (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bg_phase_q <= 1'b0;
      cp_go_q    <= 1'b0;
      cp_x_q     <= '0;
      cp_y_q     <= '0;
      mem_q      <= MEM_GAME;
      tile_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bg_phase_q <= bg_phase_d;
      cp_go_q    <= cp_go_d;
      cp_x_q     <= cp_x_d;
      cp_y_q     <= cp_y_d;
      mem_q      <= mem_d;
      tile_q     <= tile_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign cp_go            = cp_go_q;
  assign cp_x             = cp_x_q;
  assign cp_y             = cp_y_q;
  assign cp_memory_select = mem_q;
  assign cp_tile_select   = tile_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign dbg_state        = state_q;

endmodule
